// File: rtl/id_stage.sv
// Instruction-decode stage: decodes IF/ID, bypasses write-back data onto the
// register-file read ports, detects load-use hazards and loads the ID/EX register.
module id_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              if_valid,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_val,
  output logic [DATA_W-1:0] ex_rs2_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alu_src,
  output logic [2:0]        ex_alu_op,
  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;

  logic [3:0]        op;
  logic              d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump, d_alu_src;
  logic [2:0]        d_alu_op;
  logic              use_rs1, use_rs2;
  logic [DATA_W-1:0] d_imm, op1, op2;
  logic [REG_AW-1:0] d_rd;

  assign op    = if_instr[15:12];
  assign rf_a1 = if_instr[8:6];
  // S/B-type carries rs2 where other formats carry rd.
  assign rf_a2 = (op == OP_SW || op == OP_BEQ) ? if_instr[11:9] : if_instr[5:3];

  always_comb begin
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_alu_src   = 1'b0;
    d_alu_op    = 3'b000;
    use_rs1     = 1'b1;
    use_rs2     = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        d_reg_write = 1'b1;
        d_alu_op    = {1'b0, op[1:0]};
        use_rs2     = 1'b1;
      end
      OP_ADDI: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_LW: begin
        d_reg_write = 1'b1;
        d_mem_read  = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_SW: begin
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_BEQ: begin
        d_branch = 1'b1;
        d_alu_op = 3'b001;
        use_rs2  = 1'b1;
      end
      OP_JMP: begin
        d_jump  = 1'b1;
        use_rs1 = 1'b0;
      end
      default: use_rs1 = 1'b0;
    endcase
  end

  assign d_imm = (op == OP_JMP) ? {{(DATA_W-12){if_instr[11]}}, if_instr[11:0]}
                                : {{(DATA_W-6){if_instr[5]}}, if_instr[5:0]};
  assign d_rd  = (d_reg_write && if_valid) ? if_instr[11:9] : '0;

  // The register file writes on the same edge that ID/EX captures, so
  // a write-back in flight must be forwarded here.
  assign op1 = (wb_we && wb_addr != '0 && wb_addr == rf_a1) ? wb_data : rf_rd1;
  assign op2 = (wb_we && wb_addr != '0 && wb_addr == rf_a2) ? wb_data : rf_rd2;

  assign stall = ex_valid && ex_mem_read && (ex_rd != '0) && if_valid && !flush &&
                 ((use_rs1 && ex_rd == rf_a1) || (use_rs2 && ex_rd == rf_a2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_alu_op    <= 3'b000;
      stall_cnt    <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush || stall) begin
        ex_valid     <= 1'b0;
        ex_pc        <= '0;
        ex_rs1_val   <= '0;
        ex_rs2_val   <= '0;
        ex_imm       <= '0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
        ex_jump      <= 1'b0;
        ex_alu_src   <= 1'b0;
        ex_alu_op    <= 3'b000;
      end else begin
        ex_valid     <= if_valid;
        ex_pc        <= if_pc;
        ex_rs1_val   <= op1;
        ex_rs2_val   <= op2;
        ex_imm       <= d_imm;
        ex_rd        <= d_rd;
        ex_reg_write <= d_reg_write && if_valid;
        ex_mem_read  <= d_mem_read && if_valid;
        ex_mem_write <= d_mem_write && if_valid;
        ex_branch    <= d_branch && if_valid;
        ex_jump      <= d_jump && if_valid;
        ex_alu_src   <= d_alu_src && if_valid;
        ex_alu_op    <= if_valid ? d_alu_op : 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a behavioural register file and decode model predict the
// ID/EX contents, the stall output and the stall counter every cycle.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] if_instr = '0, if_pc = '0;
  logic        if_valid = 1'b0, flush = 1'b0;
  logic [2:0]  rf_a1, rf_a2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        wb_we = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        stall, ex_valid;
  logic [15:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, stall_cnt;
  logic [2:0]  ex_rd, ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src;

  id_stage dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .flush(flush), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Register file environment: R0 reads zero because it is never written.
  logic [15:0] regs [8];
  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];

  typedef struct packed {
    logic        valid;
    logic [15:0] pc, rs1, rs2, imm;
    logic [2:0]  rd;
    logic        rw, mr, mw, br, jp, as;
    logic [2:0]  aluop;
  } ex_t;

  ex_t         exp_ex;
  logic [15:0] exp_cnt;
  int          tests = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ex();
    chk("ex_valid", {15'b0, ex_valid}, {15'b0, exp_ex.valid});
    chk("ex_pc", ex_pc, exp_ex.pc);
    chk("ex_rs1_val", ex_rs1_val, exp_ex.rs1);
    chk("ex_rs2_val", ex_rs2_val, exp_ex.rs2);
    chk("ex_imm", ex_imm, exp_ex.imm);
    chk("ex_rd", {13'b0, ex_rd}, {13'b0, exp_ex.rd});
    chk("ex_ctrl", {10'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src},
        {10'b0, exp_ex.rw, exp_ex.mr, exp_ex.mw, exp_ex.br, exp_ex.jp, exp_ex.as});
    chk("ex_alu_op", {13'b0, ex_alu_op}, {13'b0, exp_ex.aluop});
    chk("stall_cnt", stall_cnt, exp_cnt);
  endtask

  function automatic logic [2:0] src2(input logic [15:0] ins);
    return (ins[15:12] == 4'd6 || ins[15:12] == 4'd7) ? ins[11:9] : ins[5:3];
  endfunction

  function automatic logic [15:0] read_val(input logic [2:0] a, input logic we,
                                           input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0000;
    if (we && wa == a) return wd;
    return regs[a];
  endfunction

  function automatic ex_t predict(input logic [15:0] ins, input logic [15:0] pc, input logic v,
                                  input logic we, input logic [2:0] wa, input logic [15:0] wd);
    ex_t r;
    int  o;
    r = '0;
    o = int'(ins[15:12]);
    r.valid = v;
    r.pc    = pc;
    r.rs1   = read_val(ins[8:6], we, wa, wd);
    r.rs2   = read_val(src2(ins), we, wa, wd);
    r.imm   = (o == 8) ? {{4{ins[11]}}, ins[11:0]} : {{10{ins[5]}}, ins[5:0]};
    if (v) begin
      if (o <= 3) begin r.rw = 1; r.aluop = 3'(o); end
      else if (o == 4) begin r.rw = 1; r.as = 1; end
      else if (o == 5) begin r.rw = 1; r.mr = 1; r.as = 1; end
      else if (o == 6) begin r.mw = 1; r.as = 1; end
      else if (o == 7) begin r.br = 1; r.aluop = 3'd1; end
      else if (o == 8) r.jp = 1;
    end
    r.rd = r.rw ? ins[11:9] : 3'd0;
    return r;
  endfunction

  task automatic step(input logic [15:0] ins, input logic [15:0] pc, input logic v, input logic fl,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      output logic stalled);
    ex_t  nxt;
    logic es, u1, u2;
    int   o;
    @(negedge clk);
    if_instr = ins; if_pc = pc; if_valid = v; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    o  = int'(ins[15:12]);
    u1 = (o <= 7);
    u2 = (o <= 3) || o == 6 || o == 7;
    es = exp_ex.valid && exp_ex.mr && exp_ex.rd != 3'd0 && v && !fl &&
         ((u1 && exp_ex.rd == ins[8:6]) || (u2 && exp_ex.rd == src2(ins)));
    chk("stall", {15'b0, stall}, {15'b0, es});
    chk("rf_a1", {13'b0, rf_a1}, {13'b0, ins[8:6]});
    chk("rf_a2", {13'b0, rf_a2}, {13'b0, src2(ins)});
    nxt = (fl || es) ? ex_t'(0) : predict(ins, pc, v, we, wa, wd);
    @(posedge clk);
    #1;
    if (we && wa != 3'd0) regs[wa] = wd;
    exp_ex = nxt;
    if (es && exp_cnt != 16'hFFFF) exp_cnt++;
    check_ex();
    stalled = es;
  endtask

  task automatic reset_regs();
    for (int i = 0; i < 8; i++) regs[i] = 16'(i);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_ex = '0;
    exp_cnt = '0;
    reset_regs();
    check_ex();
    chk("stall_in_reset", {15'b0, stall}, 16'h0000);
    #1 rst = 1'b0;
  endtask

  logic        st;
  logic [15:0] ins, pc;

  initial begin
    reset_regs();
    exp_ex = '0;
    exp_cnt = '0;
    #12 rst = 1'b0;
    #1 check_ex();

    // ADD R5,R1,R2
    step(16'h0A50, 16'h0010, 1, 0, 0, 3'd0, 16'h0, st);
    chk("add_rd_const", {13'b0, ex_rd}, 16'd5);
    chk("add_rs1_const", ex_rs1_val, 16'd1);
    chk("add_rs2_const", ex_rs2_val, 16'd2);

    // ADDI with write-back bypass on rs1
    step(16'h427F, 16'h0012, 1, 0, 1, 3'd1, 16'h00AA, st);
    chk("bypass_rs1_const", ex_rs1_val, 16'h00AA);
    chk("bypass_imm_const", ex_imm, 16'hFFFF);
    pulse_reset();

    // Load-use: LW R4 then ADD R6,R4,R2 held for one stall cycle
    step(16'h5840, 16'h0020, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h0D10, 16'h0022, 1, 0, 0, 3'd0, 16'h0, st);
    chk("loaduse_stalled", {15'b0, st}, 16'h0001);
    chk("loaduse_bubble", {15'b0, ex_valid}, 16'h0000);
    step(16'h0D10, 16'h0022, 1, 0, 0, 3'd0, 16'h0, st);
    chk("loaduse_issue", {15'b0, ex_valid}, 16'h0001);
    chk("loaduse_cnt", stall_cnt, 16'd1);

    // LW R0 followed by user of R0; LW R4 followed by ADDI with 4 in rs2 position
    step(16'h5040, 16'h0030, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h0C10, 16'h0032, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h5840, 16'h0034, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h4C60, 16'h0036, 1, 0, 0, 3'd0, 16'h0, st);

    // Flush coincident with load-use
    step(16'h5840, 16'h0040, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h0D10, 16'h0042, 1, 1, 0, 3'd0, 16'h0, st);
    chk("flush_cnt", stall_cnt, 16'd1);

    // JMP with negative imm12, and an invalid slot
    step(16'h8F00, 16'h0050, 1, 0, 0, 3'd0, 16'h0, st);
    step(16'h0A50, 16'h0052, 0, 0, 0, 3'd0, 16'h0, st);

    // Reset while a load-use stall is pending
    step(16'h5840, 16'h0060, 1, 0, 0, 3'd0, 16'h0, st);
    @(negedge clk);
    if_instr = 16'h0D10; if_valid = 1'b1; flush = 1'b0; wb_we = 1'b0;
    pulse_reset();

    // Randomized traffic; IF holds its instruction while stalled
    st = 1'b0;
    ins = '0;
    pc = 16'h0100;
    for (int n = 0; n < 400; n++) begin
      if (!st) begin
        ins = {4'($urandom_range(0, 9)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               6'($urandom)};
        pc = pc + 16'd2;
      end
      step(ins, pc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom), st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
